// File: rtl/sha256_feeder_pkg.sv
// Shared state encoding and sha256 core register map for the feeder and the core.
package sha256_feeder_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAbsorb,
        StWrWord,
        StPad,
        StKick,
        StWait,
        StRead
    } feeder_state_e;

    localparam logic [7:0] ADDR_CTRL    = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h09;
    localparam logic [7:0] ADDR_BLOCK0  = 8'h10;
    localparam logic [7:0] ADDR_DIGEST0 = 8'h20;

    localparam int unsigned CTRL_INIT_BIT    = 0;
    localparam int unsigned CTRL_NEXT_BIT    = 1;
    localparam int unsigned STATUS_READY_BIT = 0;

    localparam logic [31:0] PAD_WORD = 32'h8000_0000;

    function automatic logic [31:0] ctrl_word(input logic first_blk);
        logic [31:0] w;
        w = '0;
        if (first_blk) w[CTRL_INIT_BIT] = 1'b1;
        else           w[CTRL_NEXT_BIT] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/sha256_word_packer.sv
// Packs message bytes big-endian into a 32-bit word and inserts the 0x80 pad byte after a
// mid-word final byte.
module sha256_word_packer
    import sha256_feeder_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push_i,
    input  logic [7:0]  data_i,
    input  logic        last_i,
    input  logic        clear_i,
    output logic [31:0] word_o,
    output logic [1:0]  byte_idx_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic [4:0]  hi_bit;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        hi_bit = 5'd31 - {idx_q, 3'b000};
        if (clear_i) begin
            word_d = '0;
            idx_d  = '0;
        end else if (push_i) begin
            word_d[hi_bit -: 8] = data_i;
            // A final byte in slot 3 leaves the 0x80 for the next word.
            if (last_i && idx_q != 2'd3) word_d[hi_bit - 5'd8 -: 8] = PAD_WORD[31:24];
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_o     = word_q;
    assign byte_idx_o = idx_q;

endmodule

// File: rtl/sha256_feeder.sv
// Byte-stream front end for the sha256 core: packs and pads the message, drives the core's
// register bus block by block and reads back the digest.
module sha256_feeder
    import sha256_feeder_pkg::*;
#(
    parameter int unsigned LEN_W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         sha_cs,
    output logic         sha_we,
    output logic [7:0]   sha_address,
    output logic [31:0]  sha_write_data,
    input  logic [31:0]  sha_read_data,
    output logic         busy,
    output logic         digest_valid,
    output logic [255:0] digest
);

    feeder_state_e    state_q, state_d;
    logic [3:0]       word_idx_q, word_idx_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             first_blk_q, first_blk_d;
    logic             last_seen_q, last_seen_d;
    logic             pad80_q, pad80_d;
    logic             mark80_q, mark80_d;
    logic             len_fits_q, len_fits_d;
    logic             len_done_q, len_done_d;
    logic             wait_first_q, wait_first_d;
    logic             in_ready_q, in_ready_d;
    logic             digest_valid_q, digest_valid_d;
    logic [255:0]     digest_q, digest_d;

    logic             xfer;
    logic             pk_clear;
    logic [31:0]      pk_word;
    logic [1:0]       pk_idx;
    logic [63:0]      bit_len;
    logic [7:0]       rd_hi;

    assign xfer    = in_valid & in_ready_q;
    assign bit_len = 64'(byte_cnt_q) << 3;
    assign rd_hi   = 8'd255 - {word_idx_q[2:0], 5'b00000};

    sha256_word_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (xfer),
        .data_i     (in_data),
        .last_i     (in_last),
        .clear_i    (pk_clear),
        .word_o     (pk_word),
        .byte_idx_o (pk_idx)
    );

    always_comb begin
        state_d        = state_q;
        word_idx_d     = word_idx_q;
        byte_cnt_d     = byte_cnt_q;
        first_blk_d    = first_blk_q;
        last_seen_d    = last_seen_q;
        pad80_d        = pad80_q;
        mark80_d       = mark80_q;
        len_fits_d     = len_fits_q;
        len_done_d     = len_done_q;
        wait_first_d   = wait_first_q;
        digest_valid_d = digest_valid_q;
        digest_d       = digest_q;
        pk_clear       = 1'b0;
        sha_cs         = 1'b0;
        sha_we         = 1'b0;
        sha_address    = '0;
        sha_write_data = '0;

        unique case (state_q)
            StIdle, StAbsorb: begin
                if (xfer) begin
                    byte_cnt_d     = byte_cnt_q + LEN_W'(1);
                    digest_valid_d = 1'b0;
                    if (in_last) begin
                        last_seen_d = 1'b1;
                        pad80_d     = (pk_idx == 2'd3);
                    end
                    state_d = (in_last || pk_idx == 2'd3) ? StWrWord : StAbsorb;
                end
            end
            StWrWord: begin
                sha_cs         = 1'b1;
                sha_we         = 1'b1;
                sha_address    = ADDR_BLOCK0 + {4'b0000, word_idx_q};
                sha_write_data = pk_word;
                pk_clear       = 1'b1;
                word_idx_d     = word_idx_q + 4'd1;
                if (last_seen_q && !pad80_q && !mark80_q) begin
                    mark80_d   = 1'b1;
                    len_fits_d = (word_idx_q <= 4'd13);
                end
                if (word_idx_q == 4'd15) state_d = StKick;
                else if (last_seen_q)    state_d = StPad;
                else                     state_d = StAbsorb;
            end
            StPad: begin
                sha_cs      = 1'b1;
                sha_we      = 1'b1;
                sha_address = ADDR_BLOCK0 + {4'b0000, word_idx_q};
                word_idx_d  = word_idx_q + 4'd1;
                if (pad80_q) begin
                    sha_write_data = PAD_WORD;
                    pad80_d        = 1'b0;
                    mark80_d       = 1'b1;
                    len_fits_d     = (word_idx_q <= 4'd13);
                end else if (len_fits_q && word_idx_q == 4'd14) begin
                    sha_write_data = bit_len[63:32];
                end else if (len_fits_q && word_idx_q == 4'd15) begin
                    sha_write_data = bit_len[31:0];
                    len_done_d     = 1'b1;
                end
                if (word_idx_q == 4'd15) state_d = StKick;
            end
            StKick: begin
                sha_cs         = 1'b1;
                sha_we         = 1'b1;
                sha_address    = ADDR_CTRL;
                sha_write_data = ctrl_word(first_blk_q);
                first_blk_d    = 1'b0;
                // Pad byte already placed but length did not fit: it goes in the next block.
                if (mark80_q) len_fits_d = 1'b1;
                wait_first_d   = 1'b1;
                state_d        = StWait;
            end
            StWait: begin
                sha_cs       = 1'b1;
                sha_address  = ADDR_STATUS;
                wait_first_d = 1'b0;
                if (!wait_first_q && sha_read_data[STATUS_READY_BIT]) begin
                    if (len_done_q)       state_d = StRead;
                    else if (last_seen_q) state_d = StPad;
                    else                  state_d = StAbsorb;
                end
            end
            StRead: begin
                sha_cs               = 1'b1;
                sha_address          = ADDR_DIGEST0 + {5'b00000, word_idx_q[2:0]};
                digest_d[rd_hi -: 32] = sha_read_data;
                word_idx_d           = word_idx_q + 4'd1;
                if (word_idx_q[2:0] == 3'd7) begin
                    word_idx_d     = '0;
                    digest_valid_d = 1'b1;
                    first_blk_d    = 1'b1;
                    byte_cnt_d     = '0;
                    last_seen_d    = 1'b0;
                    pad80_d        = 1'b0;
                    mark80_d       = 1'b0;
                    len_fits_d     = 1'b0;
                    len_done_d     = 1'b0;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d == StIdle) || (state_d == StAbsorb);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            word_idx_q     <= '0;
            byte_cnt_q     <= '0;
            first_blk_q    <= 1'b1;
            last_seen_q    <= 1'b0;
            pad80_q        <= 1'b0;
            mark80_q       <= 1'b0;
            len_fits_q     <= 1'b0;
            len_done_q     <= 1'b0;
            wait_first_q   <= 1'b0;
            in_ready_q     <= 1'b0;
            digest_valid_q <= 1'b0;
            digest_q       <= '0;
        end else begin
            state_q        <= state_d;
            word_idx_q     <= word_idx_d;
            byte_cnt_q     <= byte_cnt_d;
            first_blk_q    <= first_blk_d;
            last_seen_q    <= last_seen_d;
            pad80_q        <= pad80_d;
            mark80_q       <= mark80_d;
            len_fits_q     <= len_fits_d;
            len_done_q     <= len_done_d;
            wait_first_q   <= wait_first_d;
            in_ready_q     <= in_ready_d;
            digest_valid_q <= digest_valid_d;
            digest_q       <= digest_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = (state_q != StIdle);
    assign digest_valid = digest_valid_q;
    assign digest       = digest_q;

endmodule

// File: tb/tb_sha256_feeder.sv
// Directed bench for sha256_feeder with a behavioural sha256 core on the register bus.
module tb_sha256_feeder;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         sha_cs;
    logic         sha_we;
    logic [7:0]   sha_address;
    logic [31:0]  sha_write_data;
    logic [31:0]  sha_read_data;
    logic         busy;
    logic         digest_valid;
    logic [255:0] digest;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sha256_feeder #(.LEN_W(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .sha_cs         (sha_cs),
        .sha_we         (sha_we),
        .sha_address    (sha_address),
        .sha_write_data (sha_write_data),
        .sha_read_data  (sha_read_data),
        .busy           (busy),
        .digest_valid   (digest_valid),
        .digest         (digest)
    );

    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIGEST = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, s0, s1, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {va, vb, vc, vd, ve, vf, vg, vh} = hin;
        for (int t = 0; t < 64; t++) begin
            s1 = rotr(ve, 6) ^ rotr(ve, 11) ^ rotr(ve, 25);
            t1 = vh + s1 + ((ve & vf) ^ (~ve & vg)) + K_TAB[t] + w[t];
            s0 = rotr(va, 2) ^ rotr(va, 13) ^ rotr(va, 22);
            t2 = s0 + ((va & vb) ^ (va & vc) ^ (vb & vc));
            vh = vg; vg = vf; vf = ve; ve = vd + t1;
            vd = vc; vc = vb; vb = va; va = t1 + t2;
        end
        return {hin[255:224] + va, hin[223:192] + vb, hin[191:160] + vc, hin[159:128] + vd,
                hin[127:96] + ve, hin[95:64] + vf, hin[63:32] + vg, hin[31:0] + vh};
    endfunction

    // Behavioural core: ready drops one cycle after the CTRL write, returns ~66 cycles later.
    logic [511:0] core_blk;
    logic [255:0] core_h;
    logic         core_ready;
    logic         core_pend;
    int           core_cnt;
    int           mon_viol = 0;
    logic [511:0] kick_blk [64];
    logic [31:0]  kick_dat [64];
    int           kick_n = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            core_ready <= 1'b1;
            core_pend  <= 1'b0;
            core_cnt   <= 0;
            core_h     <= '0;
        end else begin
            if (sha_we) begin
                if (!sha_cs || !core_ready || core_pend) mon_viol <= mon_viol + 1;
                if (sha_address == 8'h08) begin
                    kick_blk[kick_n % 64] <= core_blk;
                    kick_dat[kick_n % 64] <= sha_write_data;
                    kick_n    <= kick_n + 1;
                    core_h    <= sha_compress(sha_write_data[0] ? IV : core_h, core_blk);
                    core_pend <= 1'b1;
                end else if (sha_address[7:4] == 4'h1) begin
                    for (int i = 0; i < 16; i++)
                        if (sha_address[3:0] == i[3:0]) core_blk[511 - 32*i -: 32] <= sha_write_data;
                end else begin
                    mon_viol <= mon_viol + 1;
                end
            end
            if (core_pend) begin
                core_ready <= 1'b0;
                core_cnt   <= 65;
                core_pend  <= 1'b0;
            end else if (core_cnt != 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1) core_ready <= 1'b1;
            end
        end
    end

    always_comb begin
        sha_read_data = '0;
        if (sha_address == 8'h09) begin
            sha_read_data = {31'b0, core_ready};
        end else if (sha_address[7:3] == 5'b00100) begin
            for (int i = 0; i < 8; i++)
                if (sha_address[2:0] == i[2:0]) sha_read_data = core_h[255 - 32*i -: 32];
        end
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, in_ready, 1'b0);
        check({tag, " sha_cs"}, sha_cs, 1'b0);
        check({tag, " sha_we"}, sha_we, 1'b0);
        check({tag, " sha_address"}, sha_address, 8'h00);
        check({tag, " sha_write_data"}, sha_write_data, 32'h0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " digest_valid"}, digest_valid, 1'b0);
        check({tag, " digest"}, digest, 256'h0);
    endtask

    logic [7:0] msg_buf [192];

    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        t = 0;
        while (!in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) check("in_ready wait", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_msg(input int len, input int gap_max, input string name, output int base);
        int          nblk;
        int          t;
        logic [7:0]  pad [192];
        logic [511:0] eb;
        logic [255:0] h;
        logic [63:0] bl;
        base = kick_n;
        for (int i = 0; i < len; i++) begin
            send_byte(msg_buf[i], i == len - 1, (gap_max == 0) ? 0 : $urandom_range(0, gap_max));
            if (i == 0) begin
                check({name, " dv drop"}, digest_valid, 1'b0);
                check({name, " busy"}, busy, 1'b1);
            end
        end
        t = 0;
        while (!digest_valid && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check({name, " digest_valid"}, digest_valid, 1'b1);
        check({name, " idle busy"}, busy, 1'b0);

        nblk = (len + 8) / 64 + 1;
        for (int i = 0; i < nblk * 64; i++)
            pad[i] = (i < len) ? msg_buf[i] : (i == len) ? 8'h80 : 8'h00;
        bl = 64'(len) * 64'd8;
        for (int i = 0; i < 8; i++) pad[nblk*64 - 1 - i] = bl[8*i +: 8];
        check({name, " kicks"}, 512'(kick_n - base), 512'(nblk));
        h = IV;
        for (int b = 0; b < nblk; b++) begin
            for (int j = 0; j < 64; j++) eb[511 - 8*j -: 8] = pad[b*64 + j];
            check({name, " block"}, kick_blk[(base + b) % 64], eb);
            check({name, " ctrl"}, kick_dat[(base + b) % 64], (b == 0) ? 32'h1 : 32'h2);
            h = sha_compress(h, eb);
        end
        check({name, " digest"}, digest, h);
    endtask

    task automatic load_abc();
        msg_buf[0] = 8'h61;
        msg_buf[1] = 8'h62;
        msg_buf[2] = 8'h63;
    endtask

    initial begin
        int base;
        int t;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        load_abc();
        run_msg(3, 0, "abc", base);
        check("abc digest const", digest, ABC_DIGEST);
        check("abc w0", kick_blk[base % 64][511:480], 32'h61626380);
        check("abc w15", kick_blk[base % 64][31:0], 32'h18);

        for (int i = 0; i < 64; i++) msg_buf[i] = 8'h61;
        run_msg(55, 0, "a55", base);
        check("a55 w13", kick_blk[base % 64][95:64], 32'h61616180);
        check("a55 w15", kick_blk[base % 64][31:0], 32'h1B8);

        run_msg(56, 0, "a56", base);
        run_msg(64, 0, "a64", base);
        check("a64 blk2 w0", kick_blk[(base + 1) % 64][511:480], 32'h80000000);
        check("a64 blk2 w15", kick_blk[(base + 1) % 64][31:0], 32'h200);

        for (int i = 0; i < 61; i++) msg_buf[i] = 8'($urandom);
        run_msg(61, 3, "rnd61", base);
        check("dv hold", digest_valid, 1'b1);
        load_abc();
        run_msg(3, 3, "abc b2b", base);
        check("abc b2b const", digest, ABC_DIGEST);

        load_abc();
        for (int i = 0; i < 3; i++) send_byte(msg_buf[i], i == 2, 0);
        t = 0;
        while (!(sha_cs && !sha_we && sha_address == 8'h09) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("reach wait", {sha_cs, sha_we, sha_address}, {1'b1, 1'b0, 8'h09});
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("wait reset");
        @(negedge clk);
        reset_n = 1'b1;
        run_msg(3, 0, "abc post", base);
        check("abc post const", digest, ABC_DIGEST);

        check("bus monitor", 512'(mon_viol), 512'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
